// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module : ntt_pkg
// Desc   : Shared command field layout and memory-arbiter state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  localparam int c_cmd_w      = 64;
  localparam int c_opcode_lsb = 56;
  localparam int c_opcode_w   = 8;
  localparam int c_slot_lsb   = 52;
  localparam int c_slot_w     = 4;
  localparam int c_core_lsb   = 48;
  localparam int c_core_w     = 4;
  localparam int c_addr_lsb   = 0;
  localparam int c_addr_w     = 48;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT_RD = 2'd2
  } arb_state_e;

  function automatic logic [c_core_w-1:0] cmd_core_id(input logic [c_cmd_w-1:0] cmd);
    return cmd[c_core_lsb +: c_core_w];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_mem_arb.sv
`default_nettype none
// ============================================================================
// Module : ntt_mem_arb
// Desc   : Round-robin single-outstanding arbiter from NTT engines to memory.
// Rev    : 1.0 - initial release
// ============================================================================
module ntt_mem_arb
  import ntt_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 48
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        eng_req,
  input  logic [NUM_CORES-1:0]        eng_we,
  input  logic [NUM_CORES*ADDR_W-1:0] eng_addr,
  input  logic [NUM_CORES*64-1:0]     eng_wdata,
  output logic [NUM_CORES-1:0]        eng_gnt,
  output logic [NUM_CORES-1:0]        eng_valid,
  output logic [63:0]                 eng_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [63:0]                 mem_wdata,
  input  logic                        mem_gnt,
  input  logic                        mem_valid,
  input  logic [63:0]                 mem_rdata
);

  localparam int c_own_w = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  arb_state_e           r_state;
  arb_state_e           w_state_next;
  logic [c_own_w-1:0]   r_owner;
  logic [c_own_w-1:0]   w_pick;
  logic                 w_any;
  logic                 w_own_we;
  logic [ADDR_W-1:0]    w_own_addr;
  logic [63:0]          w_own_wdata;
  logic [NUM_CORES-1:0] w_own_onehot;

  // Search starts one past the last owner, so the owner register doubles as the RR pointer.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_owner;
    for (int k = 1; k <= NUM_CORES; k++) begin
      for (int j = 0; j < NUM_CORES; j++) begin
        if (!w_any && eng_req[j] && (j == (int'(r_owner) + k) % NUM_CORES)) begin
          w_any  = 1'b1;
          w_pick = c_own_w'(j);
        end
      end
    end
  end

  always_comb begin
    w_own_we     = 1'b0;
    w_own_addr   = '0;
    w_own_wdata  = '0;
    w_own_onehot = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (r_owner == c_own_w'(i)) begin
        w_own_we        = eng_we[i];
        w_own_addr      = eng_addr[i*ADDR_W +: ADDR_W];
        w_own_wdata     = eng_wdata[i*64 +: 64];
        w_own_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= c_own_w'(NUM_CORES - 1);
    end else begin
      r_state <= w_state_next;
      if (r_state == ARB_IDLE && w_any) begin
        r_owner <= w_pick;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    eng_gnt      = '0;
    eng_valid    = '0;
    eng_rdata    = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) w_state_next = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = w_own_we;
        mem_addr  = w_own_addr;
        mem_wdata = w_own_wdata;
        if (mem_gnt) begin
          eng_gnt      = w_own_onehot;
          w_state_next = w_own_we ? ARB_IDLE : ARB_WAIT_RD;
        end
      end
      ARB_WAIT_RD: begin
        if (mem_valid) begin
          eng_valid    = w_own_onehot;
          eng_rdata    = mem_rdata;
          w_state_next = ARB_IDLE;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ntt_cluster_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ntt_cluster_ctrl
// Desc   : Host command FIFO with in-order engine dispatch plus memory arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
module ntt_cluster_ctrl
  import ntt_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int CMD_DEPTH = 8,
  parameter int ADDR_W    = 48
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [63:0]                  cmd_data,
  output logic [NUM_CORES-1:0]         eng_start,
  output logic [63:0]                  eng_cmd,
  input  logic [NUM_CORES-1:0]         eng_ready,
  input  logic [NUM_CORES-1:0]         eng_req,
  input  logic [NUM_CORES-1:0]         eng_we,
  input  logic [NUM_CORES*ADDR_W-1:0]  eng_addr,
  input  logic [NUM_CORES*64-1:0]      eng_wdata,
  output logic [NUM_CORES-1:0]         eng_gnt,
  output logic [NUM_CORES-1:0]         eng_valid,
  output logic [63:0]                  eng_rdata,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [63:0]                  mem_wdata,
  input  logic                         mem_gnt,
  input  logic                         mem_valid,
  input  logic [63:0]                  mem_rdata,
  output logic [31:0]                  dispatch_count,
  output logic [15:0]                  drop_count,
  output logic [$clog2(CMD_DEPTH):0]   fifo_level
);

  localparam int c_ptr_w = $clog2(CMD_DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;

  logic [63:0]         r_fifo [CMD_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_lvl_w-1:0]  r_level;
  logic [31:0]         r_dispatch_cnt;
  logic [15:0]         r_drop_cnt;
  logic                r_last_vld;
  logic [c_core_w-1:0] r_last_id;

  logic [63:0]         w_head;
  logic [c_core_w-1:0] w_head_id;
  logic                w_head_ready;
  logic                w_accept;
  logic                w_drop;
  logic                w_push;
  logic                w_pop;

  // Ready depends only on stored state, never on a same-cycle pop.
  assign cmd_ready = (r_level != c_lvl_w'(CMD_DEPTH));
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_drop    = w_accept && (int'(cmd_core_id(cmd_data)) >= NUM_CORES);
  assign w_push    = w_accept && !w_drop;

  assign w_head    = r_fifo[r_rd_ptr];
  assign w_head_id = cmd_core_id(w_head);

  always_comb begin
    w_head_ready = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_head_id == c_core_w'(i)) w_head_ready = eng_ready[i];
    end
  end

  // Engine ready lags its start by a cycle, so back-to-back starts to one engine are suppressed.
  assign w_pop = (r_level != '0) && w_head_ready && !(r_last_vld && (r_last_id == w_head_id));

  always_comb begin
    eng_start = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      eng_start[i] = w_pop && (w_head_id == c_core_w'(i));
    end
  end

  assign eng_cmd        = w_pop ? w_head : '0;
  assign fifo_level     = r_level;
  assign dispatch_count = r_dispatch_cnt;
  assign drop_count     = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_dispatch_cnt <= '0;
      r_drop_cnt     <= '0;
      r_last_vld     <= 1'b0;
      r_last_id      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_pop) r_dispatch_cnt <= r_dispatch_cnt + 1'b1;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
      r_last_vld <= w_pop;
      r_last_id  <= w_head_id;
    end
  end

  ntt_mem_arb #(
    .NUM_CORES (NUM_CORES),
    .ADDR_W    (ADDR_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .eng_req   (eng_req),
    .eng_we    (eng_we),
    .eng_addr  (eng_addr),
    .eng_wdata (eng_wdata),
    .eng_gnt   (eng_gnt),
    .eng_valid (eng_valid),
    .eng_rdata (eng_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_ntt_cluster_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ntt_cluster_ctrl
// Desc   : Scoreboard bench for command dispatch and memory arbitration.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ntt_cluster_ctrl;
  import ntt_pkg::*;

  localparam int NUM_CORES = 4;
  localparam int CMD_DEPTH = 8;
  localparam int ADDR_W    = 48;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [63:0]                  cmd_data;
  logic [NUM_CORES-1:0]         eng_start;
  logic [63:0]                  eng_cmd;
  logic [NUM_CORES-1:0]         eng_ready;
  logic [NUM_CORES-1:0]         eng_req;
  logic [NUM_CORES-1:0]         eng_we;
  logic [NUM_CORES*ADDR_W-1:0]  eng_addr;
  logic [NUM_CORES*64-1:0]      eng_wdata;
  logic [NUM_CORES-1:0]         eng_gnt;
  logic [NUM_CORES-1:0]         eng_valid;
  logic [63:0]                  eng_rdata;
  logic                         mem_req;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [63:0]                  mem_wdata;
  logic                         mem_gnt;
  logic                         mem_valid;
  logic [63:0]                  mem_rdata;
  logic [31:0]                  dispatch_count;
  logic [15:0]                  drop_count;
  logic [$clog2(CMD_DEPTH):0]   fifo_level;

  ntt_cluster_ctrl #(
    .NUM_CORES (NUM_CORES),
    .CMD_DEPTH (CMD_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .eng_start      (eng_start),
    .eng_cmd        (eng_cmd),
    .eng_ready      (eng_ready),
    .eng_req        (eng_req),
    .eng_we         (eng_we),
    .eng_addr       (eng_addr),
    .eng_wdata      (eng_wdata),
    .eng_gnt        (eng_gnt),
    .eng_valid      (eng_valid),
    .eng_rdata      (eng_rdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_gnt        (mem_gnt),
    .mem_valid      (mem_valid),
    .mem_rdata      (mem_rdata),
    .dispatch_count (dispatch_count),
    .drop_count     (drop_count),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_start [NUM_CORES];
  logic [63:0] q_cmd [$];
  int          q_rd_core [$];
  logic [63:0] q_rd_data [$];
  logic [63:0] mon_e;
  int          mon_core;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] core, input logic [7:0] op, input logic [47:0] addr);
    logic [63:0] d;
    d = {op, 4'h3, core, addr};
    cmd_valid = 1'b1;
    cmd_data  = d;
    q_cmd.push_back(d);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_mem_req();
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    check_eq("mem_req_wait", mem_req, 1);
  endtask

  // Monitor samples mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_start != '0) begin
        check_eq("start_onehot", 64'($countones(eng_start)), 1);
        if (q_cmd.size() == 0) begin
          check_eq("start_unexpected", eng_start, 0);
        end else begin
          mon_e = q_cmd.pop_front();
          check_eq("start_cmd", eng_cmd, mon_e);
          check_eq("start_core", eng_start, 64'(1) << mon_e[51:48]);
          for (int i = 0; i < NUM_CORES; i++) begin
            if (eng_start[i]) begin
              check_eq("start_gap", 64'(cyc - last_start[i] >= 2), 1);
              last_start[i] = cyc;
            end
          end
        end
      end
      if (eng_valid != '0) begin
        if (q_rd_core.size() == 0) begin
          check_eq("valid_unexpected", eng_valid, 0);
        end else begin
          mon_core = q_rd_core.pop_front();
          mon_e    = q_rd_data.pop_front();
          check_eq("valid_core", eng_valid, 64'(1) << mon_core);
          check_eq("valid_rdata", eng_rdata, mon_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int order [3];
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    eng_ready = '0;
    eng_req   = '0;
    eng_we    = '0;
    eng_addr  = '0;
    eng_wdata = '0;
    mem_gnt   = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < NUM_CORES; i++) last_start[i] = -10;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_fifo_level", fifo_level, 0);
    check_eq("rst_dispatch", dispatch_count, 0);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_eng_start", eng_start, 0);
    check_eq("rst_eng_gnt", eng_gnt, 0);
    rst_n = 1'b1;
    tick();

    // Fill the FIFO against a busy engine, then drain at one start per two cycles.
    for (int i = 0; i < 8; i++) push_cmd(4'd1, 8'h10 + 8'(i), 48'h1000 + 48'(i));
    check_eq("full_cmd_ready", cmd_ready, 0);
    check_eq("full_level", fifo_level, 8);
    cmd_valid = 1'b1;
    cmd_data  = {8'hFF, 4'h0, 4'h1, 48'h0};
    tick();
    cmd_valid = 1'b0;
    check_eq("full_reject_level", fifo_level, 8);
    check_eq("full_reject_drop", drop_count, 0);
    eng_ready = 4'b0010;
    n = 0;
    while (fifo_level != 0 && n < 40) begin
      tick();
      n++;
    end
    check_eq("drain_cycles", 64'(n), 15);
    check_eq("drain_dispatch", dispatch_count, 8);
    check_eq("drain_sb_empty", 64'(q_cmd.size()), 0);
    check_eq("drain_cmd_ready", cmd_ready, 1);

    // Out-of-range core id is dropped.
    cmd_valid = 1'b1;
    cmd_data  = {8'h20, 4'h0, 4'h5, 48'hBEEF};
    tick();
    cmd_valid = 1'b0;
    check_eq("drop_count", drop_count, 1);
    check_eq("drop_level", fifo_level, 0);
    tick();
    check_eq("drop_dispatch", dispatch_count, 8);

    // Head blocked on a busy engine holds back later ready engines.
    eng_ready = 4'b0101;
    push_cmd(4'd3, 8'h31, 48'h3000);
    push_cmd(4'd0, 8'h32, 48'h3001);
    push_cmd(4'd2, 8'h33, 48'h3002);
    repeat (3) tick();
    check_eq("block_level", fifo_level, 3);
    check_eq("block_dispatch", dispatch_count, 8);
    eng_ready = 4'b1101;
    n = 0;
    while (fifo_level != 0 && n < 20) begin
      tick();
      n++;
    end
    check_eq("order_dispatch", dispatch_count, 11);
    check_eq("order_sb_empty", 64'(q_cmd.size()), 0);
    eng_ready = '0;

    // Three simultaneous reads served round-robin from engine 0.
    for (int i = 0; i < NUM_CORES; i++) eng_addr[i*ADDR_W +: ADDR_W] = 48'hA000 + 48'(i * 256);
    eng_we  = '0;
    eng_req = 4'b1101;
    order[0] = 0;
    order[1] = 2;
    order[2] = 3;
    for (int k = 0; k < 3; k++) begin
      wait_mem_req();
      check_eq("rd_addr", mem_addr, 48'hA000 + 48'(order[k] * 256));
      check_eq("rd_we", mem_we, 0);
      mem_gnt = 1'b1;
      #1;
      check_eq("rd_gnt", eng_gnt, 64'(1) << order[k]);
      tick();
      mem_gnt = 1'b0;
      eng_req[order[k]] = 1'b0;
      q_rd_core.push_back(order[k]);
      q_rd_data.push_back(64'hA0 + 64'(order[k]));
      mem_valid = 1'b1;
      mem_rdata = 64'hA0 + 64'(order[k]);
      tick();
      mem_valid = 1'b0;
      mem_rdata = '0;
    end
    check_eq("rd_sb_empty", 64'(q_rd_core.size()), 0);

    // Write with grant held off for three cycles.
    eng_addr[1*ADDR_W +: ADDR_W] = 48'h0000_CAFE_0010;
    eng_wdata[1*64 +: 64]        = 64'hDEAD_BEEF_0000_0001;
    eng_we  = 4'b0010;
    eng_req = 4'b0010;
    wait_mem_req();
    for (int c = 0; c < 3; c++) begin
      check_eq("wr_req_held", mem_req, 1);
      check_eq("wr_we", mem_we, 1);
      check_eq("wr_addr", mem_addr, 48'h0000_CAFE_0010);
      check_eq("wr_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0001);
      check_eq("wr_no_gnt", eng_gnt, 0);
      tick();
    end
    mem_gnt = 1'b1;
    #1;
    check_eq("wr_gnt", eng_gnt, 4'b0010);
    tick();
    mem_gnt = 1'b0;
    eng_req = '0;
    eng_we  = '0;
    check_eq("wr_gnt_pulse", eng_gnt, 0);
    check_eq("wr_idle_req", mem_req, 0);
    check_eq("wr_state", u_dut.u_arb.r_state, ARB_IDLE);
    mem_gnt   = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 64'h5555;
    #1;
    check_eq("spur_gnt", eng_gnt, 0);
    check_eq("spur_valid", eng_valid, 0);
    tick();
    mem_gnt   = 1'b0;
    mem_valid = 1'b0;
    tick();
    check_eq("spur_state", u_dut.u_arb.r_state, ARB_IDLE);

    // Reset while a read is outstanding and commands are queued.
    push_cmd(4'd2, 8'h41, 48'h4000);
    push_cmd(4'd3, 8'h42, 48'h4001);
    eng_req = 4'b0100;
    wait_mem_req();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    eng_req = '0;
    check_eq("pre_rst_state", u_dut.u_arb.r_state, ARB_WAIT_RD);
    #2;
    rst_n = 1'b0;
    #1;
    q_cmd.delete();
    check_eq("arst_cmd_ready", cmd_ready, 1);
    check_eq("arst_level", fifo_level, 0);
    check_eq("arst_dispatch", dispatch_count, 0);
    check_eq("arst_drop", drop_count, 0);
    check_eq("arst_state", u_dut.u_arb.r_state, ARB_IDLE);
    tick();
    rst_n     = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 64'hBAD;
    #1;
    check_eq("arst_no_valid", eng_valid, 0);
    tick();
    mem_valid = 1'b0;
    repeat (2) tick();
    check_eq("post_rst_state", u_dut.u_arb.r_state, ARB_IDLE);
    check_eq("post_rst_start", eng_start, 0);
    check_eq("post_rst_level", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_cluster_ctrl.md
NTT_CLUSTER_CTRL -- requirements
Module: ntt_cluster_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of attached NTT engines (1..8).
REQ-002 SHALL have parameter CMD_DEPTH, default 8, command FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter ADDR_W, default 48, memory address width.
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_data input 64: host command; [63:56] opcode, [55:52] slot, [51:48] core id, [47:0] DMA address.
REQ-007 SHALL have ports eng_start output NUM_CORES, eng_cmd output 64, eng_ready input NUM_CORES: per-engine one-cycle start, shared command bus, engine idle.
REQ-008 SHALL have per-engine memory ports eng_req, eng_we input NUM_CORES; eng_addr input NUM_CORES*ADDR_W; eng_wdata input NUM_CORES*64; eng_gnt, eng_valid output NUM_CORES; eng_rdata output 64 (shared).
REQ-009 SHALL have external memory ports mem_req, mem_we output 1; mem_addr output ADDR_W; mem_wdata output 64; mem_gnt, mem_valid input 1; mem_rdata input 64.
REQ-010 SHALL have outputs dispatch_count 32, drop_count 16, fifo_level $clog2(CMD_DEPTH)+1.

Function
REQ-011 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready = FIFO not full.
REQ-012 SHALL, for an accepted command with core id >= NUM_CORES, discard it (not enqueue) and increment drop_count (saturating at 0xFFFF).
REQ-013 SHALL, when FIFO non-empty and eng_ready[id of head] is 1, pulse eng_start[id] for exactly one cycle with eng_cmd = head entry, pop head same cycle; other eng_start bits 0.
REQ-014 SHALL dispatch strictly in order; head blocked by a busy engine blocks all later entries.
REQ-015 SHALL not dispatch to the same engine on two consecutive cycles (engine ready drops one cycle after start).
REQ-016 SHALL support simultaneous push and pop when full: pop frees the slot, cmd_ready stays as computed from pre-pop state (no combinational ready-through-pop).
REQ-017 SHALL increment dispatch_count per eng_start pulse, wrapping modulo 2^32.
REQ-018 SHALL wrap FIFO read/write pointers modulo CMD_DEPTH; fifo_level SHALL equal stored entries.
REQ-019 SHALL arbitrate memory with FSM IDLE/ISSUE/WAIT_RD: IDLE picks round-robin among asserted eng_req starting at last owner+1 and registers owner -> ISSUE.
REQ-020 SHALL in ISSUE drive mem_req=1 with owner's we/addr/wdata; on mem_gnt pulse eng_gnt[owner]; write -> IDLE, read -> WAIT_RD.
REQ-021 SHALL in WAIT_RD, on mem_valid, pulse eng_valid[owner] with eng_rdata=mem_rdata same cycle, then -> IDLE.
REQ-022 SHALL keep exactly one memory transaction outstanding; requests from non-owners wait.
REQ-023 SHALL ignore mem_valid outside WAIT_RD and mem_gnt outside ISSUE.

Reset
REQ-024 SHALL on rst_n low asynchronously clear FIFO, counters, FSM to IDLE, round-robin pointer to NUM_CORES-1 (first grant to engine 0); all outputs 0 except cmd_ready=1.
REQ-025 SHALL discard any in-flight memory transaction and queued commands on reset mid-operation; no eng_valid after deassertion for the abandoned read.

Structure
REQ-026 SHALL place command field offsets (opcode, slot, core id, address) and arbiter state encodings in shared package ntt_pkg.
REQ-027 SHALL implement memory arbitration as sub-module ntt_mem_arb; FIFO and dispatch in top level.

Verification
REQ-028 Push 8 commands to core 1 with eng_ready[1]=0 -> cmd_ready=0 after 8th, fifo_level=8; raise ready -> one start per 2 cycles, dispatch_count=8.
REQ-029 Command with core id 5, NUM_CORES=4 -> no eng_start, drop_count=1, fifo_level unchanged.
REQ-030 Engines 0,2,3 assert eng_req reads together -> grants in order 0,2,3, each eng_valid carries matching mem_rdata (e.g. 0xA0, 0xA2, 0xA3).
REQ-031 Write from engine 1 with mem_gnt delayed 3 cycles -> mem_req held 3 cycles with stable addr/wdata, eng_gnt[1] single pulse, FSM back to IDLE, no eng_valid.
REQ-032 Assert rst_n low during WAIT_RD, then deliver mem_valid -> no eng_valid, FSM IDLE, counters 0, cmd_ready=1.
